dpb_stream_reader: RTL
======================

DPB_STREAM_READER -- requirements
Module: dpb_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM address width (2048 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, RAM and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; minimum 3.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1, the request handshake.
REQ-007 SHALL have port req_addr  in  ADDR_W  start byte address.
REQ-008 SHALL have port req_len  in  ADDR_W+1  byte count, 0..2048.
REQ-009 SHALL have RAM-port outputs mem_ce 1, mem_oce 1, mem_wre 1, mem_ad ADDR_W, and input mem_dout DATA_W; these drive a 2-cycle pipelined read port.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1 / out_data out DATA_W / out_last out 1, the byte stream.
REQ-011 SHALL have ports busy out 1 (request active) and done out 1 (one-cycle completion pulse).
REQ-012 SHALL have port trunc  out  1, asserted with done when a request was cut at the top of memory.

Function
REQ-013 SHALL implement states IDLE, RUN and DRAIN.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&req_ready.
REQ-015 On acceptance with req_len=0, SHALL stay in IDLE and pulse done on the next cycle with no beats.
REQ-016 On acceptance with req_len>0, SHALL latch address and count and enter RUN.
REQ-017 In RUN, SHALL issue one read per cycle (mem_ce=1, mem_ad=current address) only when FIFO occupancy plus reads in flight is less than FIFO_DEPTH.
REQ-018 SHALL hold mem_oce=1 at all times and mem_wre=0 at all times.
REQ-019 SHALL track reads in flight with a 2-stage valid pipeline and write mem_dout into the FIFO exactly 2 cycles after the issue cycle.
REQ-020 SHALL sustain one beat per cycle when out_ready is held high.
REQ-021 SHALL never drop or duplicate a beat under any out_ready pattern.
REQ-022 SHALL present out_data from the FIFO head, and out_valid SHALL mean the FIFO is non-empty; out_data SHALL be stable while out_valid&!out_ready.
REQ-023 SHALL assert out_last on the final beat of a request.
REQ-024 SHALL enter DRAIN after the last read is issued.
REQ-025 SHALL leave DRAIN for IDLE on the handshake of the out_last beat, pulsing done (and trunc if applicable) on the following cycle.
REQ-026 SHALL hold busy=1 in RUN and DRAIN and busy=0 in IDLE.

Reset
REQ-027 On reset SHALL enter IDLE and clear the FIFO, the in-flight pipeline and the counters.
REQ-028 Outputs SHALL reset to: req_ready=1, mem_ce=0, mem_oce=1, mem_wre=0, mem_ad=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, trunc=0.
REQ-029 Reset mid-request SHALL discard all in-flight data with no done pulse.

Configuration
REQ-030 With ADDR_WRAP_EN defined, the address SHALL wrap from 2047 to 0 and the full req_len SHALL be delivered; trunc SHALL be tied to 0.
REQ-031 Without ADDR_WRAP_EN, issuing SHALL stop after address 2047, out_last SHALL mark the last delivered beat, and trunc SHALL pulse with done.

Structure
REQ-032 The shared package SHALL hold the state enum, the RAM read-latency constant (2) and the default widths.
REQ-033 The FIFO SHALL be the sub-module stream_fifo (synchronous, show-ahead, parameterised depth and width).

Verification
REQ-034 Request addr=0x010, len=4, out_ready=1, RAM[i]=i[7:0] -> beats 0x10..0x13; out_last on 0x13; done pulses 1 cycle after the last handshake; busy is high from acceptance until the done cycle.
REQ-035 Request len=16 with out_ready toggling 1/0 each cycle -> all 16 bytes delivered in order, never more than FIFO_DEPTH reads outstanding, no loss.
REQ-036 Request addr=0x7FE, len=4 -> with ADDR_WRAP_EN: bytes at 7FE, 7FF, 000, 001 and trunc=0; without it: 2 beats and trunc=1 with done.
REQ-037 Request len=0 -> no beats; done pulses on the next cycle; req_ready stays 1.
REQ-038 Assert reset 3 cycles into a len=8 request with out_ready=0 -> out_valid=0 and busy=0 immediately; no done; a following len=2 request completes correctly.
REQ-039 out_ready=1 throughout a len=64 request -> 64 consecutive beats, with the first beat 3 cycles after acceptance.

Source files
------------

// File: rtl/dpb_stream_reader_pkg.sv
// Shared definitions for the DPB stream reader.
//   - state_t          : controller states (IDLE / RUN / DRAIN)
//   - RD_LATENCY       : read latency of the pipelined RAM port, in cycles
//   - DEF_*            : default widths and output buffer depth
//   - inflight_count() : number of reads currently travelling through the
//                        RAM pipeline, given its valid bits
package dpb_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RD_LATENCY     = 2;
    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int inflight_count(input logic [RD_LATENCY-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dpb_stream_reader_fifo.sv
// stream_fifo: synchronous show-ahead FIFO used as the output buffer of the
// stream reader. The head entry is always visible on rd_data while not empty.
// Ports:
//   clk, reset (async, active high)
//   wr_en / wr_data : push (ignored when full)
//   rd_en / rd_data : pop of the head entry (ignored when empty)
//   empty           : no entries held
//   count           : current occupancy, 0..DEPTH
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH-1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign do_wr_s = wr_en && (count_r != CW'(DEPTH));
    assign do_rd_s = rd_en && (count_r != {CW{1'b0}});
    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (do_rd_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dpb_stream_reader.sv
// dpb_stream_reader: reads req_len bytes starting at req_addr from a RAM with a
// 2-cycle pipelined read port and streams them out with valid/ready.
// Ports:
//   clk, reset (async, active high)
//   req_valid/req_ready, req_addr, req_len : request handshake (len 0..2^ADDR_W)
//   mem_ce, mem_oce, mem_wre, mem_ad, mem_dout : RAM read port
//   out_valid/out_ready, out_data, out_last     : byte stream
//   busy  : request in progress
//   done  : one-cycle completion pulse
//   trunc : with done, request was cut at the top of memory
// Build option ADDR_WRAP_EN: when defined, addresses wrap from the top of memory
// back to 0 and the full length is always delivered (trunc stays 0). When not
// defined, reading stops at the top address and the request is truncated.
module dpb_stream_reader
    import dpb_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W:0]   req_len,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              trunc
);

    localparam int LW = ADDR_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t                  state_r;
    state_t                  state_nx;
    logic [ADDR_W-1:0]       addr_r;
    logic [ADDR_W:0]         remain_r;
    logic                    cut_r;
    logic                    done_r;
    logic                    trunc_r;
    logic [RD_LATENCY-1:0]   pipe_v_r;
    logic [RD_LATENCY-1:0]   pipe_last_r;

    logic                    accept_s;
    logic                    issue_s;
    logic                    at_top_s;
    logic                    last_issue_s;
    logic                    cut_s;
    logic                    pop_s;
    logic                    finish_s;
    logic [DATA_W:0]         fifo_rd_s;
    logic                    fifo_empty_s;
    logic [CW-1:0]           fifo_count_s;

    // Output buffer: each entry carries the data byte plus its last-beat flag.
    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pipe_v_r[RD_LATENCY-1]),
        .wr_data ({pipe_last_r[RD_LATENCY-1], mem_dout}),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_rd_s[DATA_W-1:0];
    assign out_last  = !fifo_empty_s && fifo_rd_s[DATA_W];
    assign pop_s     = out_valid && out_ready;
    assign accept_s  = req_valid && (state_r == ST_IDLE);
    assign finish_s  = (state_r == ST_DRAIN) && pop_s && out_last;
    assign done      = done_r;
    assign trunc     = trunc_r;

    // Credit check: a read is only issued if its byte is guaranteed a FIFO slot
    // counting everything already buffered or still inside the RAM pipeline.
    assign issue_s = (state_r == ST_RUN) &&
                     ((int'(fifo_count_s) + inflight_count(pipe_v_r)) < FIFO_DEPTH);

`ifdef ADDR_WRAP_EN
    assign at_top_s = 1'b0;
`else
    assign at_top_s = (addr_r == {ADDR_W{1'b1}});
`endif
    assign last_issue_s = (remain_r == LW'(1)) || at_top_s;
    assign cut_s        = at_top_s && (remain_r != LW'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and RAM/handshake outputs.
    always_comb begin
        state_nx  = state_r;
        req_ready = 1'b0;
        busy      = 1'b0;
        mem_ce    = issue_s;
        mem_oce   = 1'b1;
        mem_wre   = 1'b0;
        mem_ad    = addr_r;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_len != LW'(0))) begin
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (issue_s && last_issue_s) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (finish_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Address / remaining-count tracking and the truncation marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r   <= {ADDR_W{1'b0}};
            remain_r <= {LW{1'b0}};
            cut_r    <= 1'b0;
        end else if (accept_s) begin
            addr_r   <= req_addr;
            remain_r <= req_len;
            cut_r    <= 1'b0;
        end else if (issue_s) begin
            addr_r   <= addr_r + ADDR_W'(1);
            remain_r <= remain_r - LW'(1);
            cut_r    <= cut_r || (last_issue_s && cut_s);
        end
    end

    // Valid/last shift register mirroring the RAM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v_r    <= {RD_LATENCY{1'b0}};
            pipe_last_r <= {RD_LATENCY{1'b0}};
        end else begin
            pipe_v_r    <= {pipe_v_r[RD_LATENCY-2:0], issue_s};
            pipe_last_r <= {pipe_last_r[RD_LATENCY-2:0], issue_s && last_issue_s};
        end
    end

    // Completion pulse, one cycle after a zero-length accept or the final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r  <= 1'b0;
            trunc_r <= 1'b0;
        end else begin
            done_r  <= (accept_s && (req_len == LW'(0))) || finish_s;
            trunc_r <= finish_s && cut_r;
        end
    end

endmodule
